// File: rtl/aes_v2_sbox_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_v2_sbox_arbiter_pkg
// Purpose  : Shared state encodings, requester indices and byte-select helper
//            for the shared AES sbox arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package aes_v2_sbox_arbiter_pkg;

  // Sequencer states: idle, then one state per byte of the granted word.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4
  } state_e;

  // Requester indices as stored in the grant register.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Byte of the granted word that feeds the sbox in a given byte state.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input state_e st);
    logic [7:0] b;
    case (st)
      ST_B1:   b = word[15:8];
      ST_B2:   b = word[23:16];
      ST_B3:   b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_v2_sbox_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_v2_sbox_arbiter_if
// Purpose  : Two-requester word substitution bus. The master modport is the
//            requester side, the slave modport is the arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_v2_sbox_arbiter_if;

  logic        r0_valid;
  logic [31:0] r0_data;
  logic        r0_inv;
  logic        r0_ready;
  logic        r1_valid;
  logic [31:0] r1_data;
  logic        r1_inv;
  logic        r1_ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output r0_valid, r0_data, r0_inv,
    output r1_valid, r1_data, r1_inv,
    input  r0_ready, r1_ready, result, busy
  );

  modport slave (
    input  r0_valid, r0_data, r0_inv,
    input  r1_valid, r1_data, r1_inv,
    output r0_ready, r1_ready, result, busy
  );

endinterface
`default_nettype wire

// File: rtl/aes_v2_sbox_arbiter_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_v2_sbox_arbiter_sbox
// Purpose  : Combinational AES forward/inverse sbox built from GF(2^8)
//            inversion (x^254) and the AES affine transform.
// Revision : 1.0 - initial release
// ============================================================================
module aes_v2_sbox_arbiter_sbox (
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via an addition chain; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a3, a7, a15, a31, a63, a127;
    a3   = gf_mul(gf_mul(a, a), a);
    a7   = gf_mul(gf_mul(a3, a3), a);
    a15  = gf_mul(gf_mul(a7, a7), a);
    a31  = gf_mul(gf_mul(a15, a15), a);
    a63  = gf_mul(gf_mul(a31, a31), a);
    a127 = gf_mul(gf_mul(a63, a63), a);
    return gf_mul(a127, a127);
  endfunction

  // Forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] fwd_aff(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] inv_aff(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // Select forward or inverse substitution.
  always_comb begin
    if (inv) out = gf_inv(inv_aff(in));
    else     out = fwd_aff(gf_inv(in));
  end

endmodule
`default_nettype wire

// File: rtl/aes_v2_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_v2_sbox_arbiter
// Purpose  : Round-robin arbiter sharing one AES sbox between two word
//            requesters; substitutes the granted word one byte per cycle and
//            returns the full word with a one-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module aes_v2_sbox_arbiter
  import aes_v2_sbox_arbiter_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic                        g_clk,
  input  logic                        g_resetn,
  aes_v2_sbox_arbiter_if.slave        bus
);

  state_e      fsm_q, fsm_d;
  logic        gnt_q, gnt_d;
  logic        prio_q, prio_d;
  logic [7:0]  b0_q, b0_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;

  logic [7:0]  sbox_in;
  logic        sbox_inv;
  logic [7:0]  sbox_out;

  logic        gnt_valid;
  logic        gnt_inv;
  logic [31:0] gnt_data;
  logic        other_valid;
  logic        win;
  logic        done;

  // Granted requester's live request; no copy of the word is kept.
  assign gnt_valid   = (gnt_q == REQ1) ? bus.r1_valid : bus.r0_valid;
  assign gnt_inv     = (gnt_q == REQ1) ? bus.r1_inv   : bus.r0_inv;
  assign gnt_data    = (gnt_q == REQ1) ? bus.r1_data  : bus.r0_data;
  assign other_valid = (gnt_q == REQ1) ? bus.r0_valid : bus.r1_valid;

  // Winner when arbitrating from idle: prio on a tie, else whoever asks.
  assign win = (bus.r0_valid && bus.r1_valid) ? prio_q : bus.r1_valid;

  aes_v2_sbox_arbiter_sbox u_sbox (
    .in  (sbox_in),
    .inv (sbox_inv),
    .out (sbox_out)
  );

  // Steer the current byte of the granted word into the shared sbox.
  always_comb begin
    sbox_in  = 8'h00;
    sbox_inv = 1'b0;
    if (fsm_q != ST_IDLE) begin
      sbox_in  = byte_sel(gnt_data, fsm_q);
      sbox_inv = gnt_inv;
    end
  end

  // Arbitration, byte capture and state sequencing.
  always_comb begin
    fsm_d  = fsm_q;
    gnt_d  = gnt_q;
    prio_d = prio_q;
    b0_d   = b0_q;
    b1_d   = b1_q;
    b2_d   = b2_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.r0_valid || bus.r1_valid) begin
          gnt_d  = win;
          prio_d = ~win;
          fsm_d  = ST_B0;
        end
      end
      ST_B0: begin
        if (!gnt_valid) fsm_d = ST_IDLE;
        else begin
          b0_d  = sbox_out;
          fsm_d = ST_B1;
        end
      end
      ST_B1: begin
        if (!gnt_valid) fsm_d = ST_IDLE;
        else begin
          b1_d  = sbox_out;
          fsm_d = ST_B2;
        end
      end
      ST_B2: begin
        if (!gnt_valid) fsm_d = ST_IDLE;
        else begin
          b2_d  = sbox_out;
          fsm_d = ST_B3;
        end
      end
      ST_B3: begin
        // Hand straight over to the other requester; never regrant the one just served.
        if (gnt_valid && other_valid) begin
          gnt_d  = ~gnt_q;
          prio_d = gnt_q;
          fsm_d  = ST_B0;
        end else begin
          fsm_d  = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge g_clk) begin
    if (g_resetn) begin
      fsm_q  <= ST_IDLE;
      gnt_q  <= REQ0;
      prio_q <= RR_INIT;
      b0_q   <= 8'h00;
      b1_q   <= 8'h00;
      b2_q   <= 8'h00;
    end else begin
      fsm_q  <= fsm_d;
      gnt_q  <= gnt_d;
      prio_q <= prio_d;
      b0_q   <= b0_d;
      b1_q   <= b1_d;
      b2_q   <= b2_d;
    end
  end

  // Completion only while the owner still holds valid; outputs forced low in reset.
  assign done         = (fsm_q == ST_B3) && gnt_valid && !g_resetn;
  assign bus.r0_ready = done && (gnt_q == REQ0);
  assign bus.r1_ready = done && (gnt_q == REQ1);
  assign bus.result   = done ? {sbox_out, b2_q, b1_q, b0_q} : 32'h0000_0000;
  assign bus.busy     = (fsm_q != ST_IDLE) && !g_resetn;

endmodule
`default_nettype wire

// File: tb/tb_aes_v2_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_v2_sbox_arbiter
// Purpose  : Self-checking bench for the shared sbox arbiter: directed
//            scenarios followed by randomized two-requester traffic, checked
//            every cycle against a transaction-level model with a table sbox.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_v2_sbox_arbiter;

  localparam bit RR = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_v2_sbox_arbiter_if bus ();

  aes_v2_sbox_arbiter #(.RR_INIT(RR)) u_dut (
    .g_clk    (clk),
    .g_resetn (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [2047:0] tab_bits;
  logic [7:0]    fwd_tab [256];
  logic [7:0]    inv_tab [256];

  // Model: owner -1 when idle, phase = byte index being processed.
  int m_owner = -1;
  int m_phase = 0;
  int m_prio  = 0;

  logic        o_r0, o_r1, o_busy;
  logic [31:0] o_res;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = inv ? inv_tab[w[8*k +: 8]] : fwd_tab[w[8*k +: 8]];
    return r;
  endfunction

  function automatic logic vld_of(input int idx);
    return (idx == 1) ? bus.r1_valid : bus.r0_valid;
  endfunction

  // One cycle: check outputs against the model, advance the model, step the clock.
  task automatic tick();
    logic        e_r0, e_r1, e_busy;
    logic [31:0] e_res;
    int          w;
    @(negedge clk);
    e_r0 = 1'b0; e_r1 = 1'b0; e_busy = 1'b0; e_res = 32'h0;
    if (!rst) begin
      e_busy = (m_owner >= 0);
      if (m_owner >= 0 && m_phase == 3 && vld_of(m_owner)) begin
        if (m_owner == 0) begin
          e_r0  = 1'b1;
          e_res = sub_word(bus.r0_data, bus.r0_inv);
        end else begin
          e_r1  = 1'b1;
          e_res = sub_word(bus.r1_data, bus.r1_inv);
        end
      end
    end
    o_r0 = bus.r0_ready; o_r1 = bus.r1_ready; o_res = bus.result; o_busy = bus.busy;
    check_val("r0_ready", {31'd0, o_r0}, {31'd0, e_r0});
    check_val("r1_ready", {31'd0, o_r1}, {31'd0, e_r1});
    check_val("result", o_res, e_res);
    check_val("busy", {31'd0, o_busy}, {31'd0, e_busy});
    if (rst) begin
      m_owner = -1; m_phase = 0; m_prio = int'(RR);
    end else if (m_owner < 0) begin
      if (bus.r0_valid || bus.r1_valid) begin
        w = (bus.r0_valid && bus.r1_valid) ? m_prio : (bus.r1_valid ? 1 : 0);
        m_owner = w; m_phase = 0; m_prio = 1 - w;
      end
    end else if (!vld_of(m_owner)) begin
      m_owner = -1;
    end else if (m_phase < 3) begin
      m_phase++;
    end else if (vld_of(1 - m_owner)) begin
      m_owner = 1 - m_owner; m_phase = 0; m_prio = 1 - m_owner;
    end else begin
      m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  // Run a bounded window; record first ready cycle/result per requester and drop valid on ready.
  task automatic run_req(input int max_cyc, output int c0, output int c1,
                         output logic [31:0] res0, output logic [31:0] res1,
                         output logic busy_first);
    c0 = -1; c1 = -1; res0 = 32'h0; res1 = 32'h0; busy_first = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      if (c == 0) busy_first = o_busy;
      if (o_r0 && c0 < 0) begin c0 = c; res0 = o_res; end
      if (o_r1 && c1 < 0) begin c1 = c; res1 = o_res; end
      if (o_r0) bus.r0_valid = 1'b0;
      if (o_r1) bus.r1_valid = 1'b0;
    end
  endtask

  // Random requester behaviour that honours the hold-until-ready protocol most of the time.
  task automatic drive_req(input int idx);
    logic v, seen, nv, ni;
    logic [31:0] nd;
    v    = (idx == 1) ? bus.r1_valid : bus.r0_valid;
    seen = (idx == 1) ? o_r1 : o_r0;
    nd   = (idx == 1) ? bus.r1_data : bus.r0_data;
    ni   = (idx == 1) ? bus.r1_inv : bus.r0_inv;
    nv   = v;
    if (v && seen) begin
      if ($urandom_range(0, 1) == 1) nv = 1'b0;
      else begin nd = $urandom; ni = ($urandom_range(0, 1) == 1); end
    end else if (v) begin
      if ($urandom_range(0, 39) == 0) nv = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      nv = 1'b1; nd = $urandom; ni = ($urandom_range(0, 1) == 1);
    end
    if (idx == 1) begin bus.r1_valid = nv; bus.r1_data = nd; bus.r1_inv = ni; end
    else          begin bus.r0_valid = nv; bus.r0_data = nd; bus.r0_inv = ni; end
  endtask

  initial begin
    int          c0, c1, pstart;
    logic [31:0] res0, res1;
    logic        bf;

    tab_bits = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) fwd_tab[i] = tab_bits[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = i[7:0];

    bus.r0_valid = 1'b0; bus.r0_data = 32'h0; bus.r0_inv = 1'b0;
    bus.r1_valid = 1'b0; bus.r1_data = 32'h0; bus.r1_inv = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single forward request of an all-zero word from requester 0.
    bus.r0_valid = 1'b1; bus.r0_data = 32'h0000_0000; bus.r0_inv = 1'b0;
    run_req(8, c0, c1, res0, res1, bf);
    check_val("t1_busy0", {31'd0, bf}, 32'd0);
    check_val("t1_cyc", c0, 32'd4);
    check_val("t1_res", res0, 32'h6363_6363);
    check_val("t1_r1", c1, 32'hffff_ffff);

    // Requester 1 forward word: byte ordering.
    bus.r1_valid = 1'b1; bus.r1_data = 32'h5301_0063; bus.r1_inv = 1'b0;
    run_req(8, c0, c1, res0, res1, bf);
    check_val("t2_cyc", c1, 32'd4);
    check_val("t2_res", res1, 32'hed7c_63fb);

    // Both valid with prio on requester 0: back-to-back, no idle bubble.
    bus.r0_valid = 1'b1; bus.r0_data = 32'h0101_0101; bus.r0_inv = 1'b0;
    bus.r1_valid = 1'b1; bus.r1_data = 32'h6363_6363; bus.r1_inv = 1'b1;
    run_req(12, c0, c1, res0, res1, bf);
    check_val("t3_r0cyc", c0, 32'd4);
    check_val("t3_r0res", res0, 32'h7c7c_7c7c);
    check_val("t3_r1cyc", c1, 32'd8);
    check_val("t3_r1res", res1, 32'h0000_0000);

    // Both valid again: the preferred requester goes first, the other 4 cycles later.
    pstart = m_prio;
    bus.r0_valid = 1'b1; bus.r0_data = $urandom; bus.r0_inv = 1'b0;
    bus.r1_valid = 1'b1; bus.r1_data = $urandom; bus.r1_inv = 1'b1;
    run_req(12, c0, c1, res0, res1, bf);
    check_val("t4_first", (pstart == 0) ? c0 : c1, 32'd4);
    check_val("t4_second", (pstart == 0) ? c1 : c0, 32'd8);

    // Granted requester abandons its word during B1.
    bus.r0_valid = 1'b1; bus.r0_data = $urandom; bus.r0_inv = 1'b0;
    tick();
    tick();
    bus.r0_valid = 1'b0;
    tick();
    check_val("t5_busy_b1", {31'd0, o_busy}, 32'd1);
    tick();
    check_val("t5_busy_idle", {31'd0, o_busy}, 32'd0);
    check_val("t5_no_rdy", {31'd0, o_r0}, 32'd0);
    bus.r1_valid = 1'b1; bus.r1_data = $urandom; bus.r1_inv = 1'b0;
    run_req(8, c0, c1, res0, res1, bf);
    check_val("t5_r1cyc", c1, 32'd4);

    // Reset during B2, then both requesters contend under the reset priority.
    bus.r0_valid = 1'b1; bus.r0_data = $urandom; bus.r0_inv = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_val("t6_rst_res", o_res, 32'h0);
    check_val("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    bus.r1_valid = 1'b1; bus.r1_data = $urandom; bus.r1_inv = 1'b0;
    run_req(12, c0, c1, res0, res1, bf);
    check_val("t6_idle", {31'd0, bf}, 32'd0);
    check_val("t6_first", (RR == 1'b0) ? c0 : c1, 32'd4);
    check_val("t6_second", (RR == 1'b0) ? c1 : c0, 32'd8);

    // Randomized traffic with occasional resets and protocol violations.
    o_r0 = 1'b0; o_r1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive_req(0);
      drive_req(1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
